// File: rtl/fft_bitrev_reorder.sv
// rtl/fft_bitrev_reorder.sv - ping-pong bit-reversed to natural-order reorder buffer for the SDF FFT output
// Optional build macro FFT_REORDER_HALF_EN: read out bins 0..N/2-1 only.
module fft_bitrev_reorder #(
  parameter  int N     = 256,
  parameter  int WIDTH = 32,
  localparam int LOG2N = $clog2(N)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG2N-1:0] do_idx,
  output logic             do_last
);

  localparam logic [LOG2N-1:0] WR_LAST = LOG2N'(N - 1);
`ifdef FFT_REORDER_HALF_EN
  localparam logic [LOG2N-1:0] RD_LAST = LOG2N'(N / 2 - 1);
`else
  localparam logic [LOG2N-1:0] RD_LAST = LOG2N'(N - 1);
`endif

  typedef enum logic {IDLE, READ} state_t;

  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction

  // Both banks share one array; the top address bit selects the bank.
  logic [2*WIDTH-1:0] mem [0:2*N-1];

  logic [LOG2N-1:0] wr_cnt;
  logic             wr_bank;
  logic [1:0]       full;
  state_t           state;
  logic [LOG2N-1:0] rd_cnt;
  logic             rd_bank;

  logic frame_done;
  logic rd_active;
  logic rd_last;
  logic other_ready;

  assign frame_done  = di_en && (wr_cnt == WR_LAST);
  assign rd_active   = (state == READ);
  assign rd_last     = rd_active && (rd_cnt == RD_LAST);
  // The other bank may be completing on this very edge; that keeps the stream gapless.
  assign other_ready = full[~rd_bank] || (frame_done && (wr_bank != rd_bank));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt  <= '0;
      wr_bank <= 1'b0;
    end else if (di_en) begin
      wr_cnt <= wr_cnt + 1'b1;
      if (frame_done) wr_bank <= ~wr_bank;
    end
  end

  always_ff @(posedge clock) begin
    if (di_en) mem[{wr_bank, bitrev(wr_cnt)}] <= {di_re, di_im};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (frame_done && (wr_bank == 1'(b)))
          full[b] <= 1'b1;
        else if (rd_last && (rd_bank == 1'(b)))
          full[b] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      rd_cnt  <= '0;
      rd_bank <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          rd_cnt <= '0;
          if (full[rd_bank]) begin
            state <= READ;
          end else if (full[~rd_bank]) begin
            state   <= READ;
            rd_bank <= ~rd_bank;
          end
        end
        READ: begin
          if (rd_cnt == RD_LAST) begin
            rd_cnt <= '0;
            if (other_ready) rd_bank <= ~rd_bank;
            else             state   <= IDLE;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Registered RAM read doubles as the output stage.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      do_en   <= 1'b0;
      do_last <= 1'b0;
      do_idx  <= '0;
      do_re   <= '0;
      do_im   <= '0;
    end else begin
      do_en   <= rd_active;
      do_last <= rd_last;
      if (rd_active) begin
        do_idx         <= rd_cnt;
        {do_re, do_im} <= mem[{rd_bank, rd_cnt}];
      end
    end
  end

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// tb/tb_fft_bitrev_reorder.sv - directed self-checking bench for fft_bitrev_reorder
module tb_fft_bitrev_reorder;

  localparam int N     = 256;
  localparam int WIDTH = 32;
  localparam int LOG2N = 8;
`ifdef FFT_REORDER_HALF_EN
  localparam int NOUT = N / 2;
`else
  localparam int NOUT = N;
`endif

  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             di_en = 1'b0;
  logic [WIDTH-1:0] di_re = '0;
  logic [WIDTH-1:0] di_im = '0;
  logic             do_en;
  logic [WIDTH-1:0] do_re;
  logic [WIDTH-1:0] do_im;
  logic [LOG2N-1:0] do_idx;
  logic             do_last;

  fft_bitrev_reorder #(.N(N), .WIDTH(WIDTH)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .di_en  (di_en),
    .di_re  (di_re),
    .di_im  (di_im),
    .do_en  (do_en),
    .do_re  (do_re),
    .do_im  (do_im),
    .do_idx (do_idx),
    .do_last(do_last)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  logic [31:0] q_re[$];
  logic [31:0] q_im[$];
  int          q_idx[$];
  logic        q_last[$];
  int          q_cyc[$];

  always @(negedge clock) begin
    if (do_en === 1'b1) begin
      q_re.push_back(do_re);
      q_im.push_back(do_im);
      q_idx.push_back(int'(do_idx));
      q_last.push_back(do_last);
      q_cyc.push_back(cyc);
    end
  end

  int errors = 0;
  int checks = 0;
  int last_in_edge = 0;

  function automatic int br8(input int x);
    int r = 0;
    for (int i = 0; i < 8; i++) if (x[i]) r = r | (1 << (7 - i));
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clear_q();
    q_re.delete(); q_im.delete(); q_idx.delete(); q_last.delete(); q_cyc.delete();
  endtask

  task automatic send_frame(input int offset, input int gap);
    for (int j = 0; j < N; j++) begin
      @(negedge clock);
      di_en = 1'b1;
      di_re = 32'(offset + j);
      di_im = 32'(-(offset + j));
      last_in_edge = cyc + 1;
      for (int g = 0; g < gap; g++) begin
        @(negedge clock);
        di_en = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      di_en = 1'b0;
    end
  endtask

  task automatic check_frames(input string tag, input int nframes, input int step, input bit chk_lat);
    int bad_d, bad_i, bad_l, bad_c, k;
    logic [31:0] v;
    bad_d = 0; bad_i = 0; bad_l = 0; bad_c = 0;
    check({tag, ".count"}, q_re.size(), nframes * NOUT);
    if (q_re.size() == nframes * NOUT) begin
      for (int f = 0; f < nframes; f++) begin
        for (int i = 0; i < NOUT; i++) begin
          k = f * NOUT + i;
          v = 32'(f * step + br8(i));
          if (q_re[k] !== v)  bad_d++;
          if (q_im[k] !== -v) bad_d++;
          if (q_idx[k] != i) bad_i++;
          if (q_last[k] !== (i == NOUT - 1)) bad_l++;
          if (q_cyc[k] != q_cyc[0] + f * N + i) bad_c++;
        end
        check({tag, ".idx1"}, q_re[f*NOUT+1], 32'(f * step + 128));
        check({tag, ".idx2"}, q_re[f*NOUT+2], 32'(f * step + 64));
        check({tag, ".idx3"}, q_re[f*NOUT+3], 32'(f * step + 192));
`ifdef FFT_REORDER_HALF_EN
        check({tag, ".idx127"}, q_re[f*NOUT+127], 32'(f * step + 254));
`else
        check({tag, ".idx255"}, q_re[f*NOUT+255], 32'(f * step + 255));
`endif
        check({tag, ".lastflag"}, 32'(q_last[f*NOUT+NOUT-1]), 32'd1);
      end
      check({tag, ".data_bad"}, bad_d, 0);
      check({tag, ".idx_bad"}, bad_i, 0);
      check({tag, ".last_bad"}, bad_l, 0);
      check({tag, ".contig_bad"}, bad_c, 0);
      if (chk_lat) check({tag, ".latency"}, 32'(q_cyc[0] - last_in_edge), 32'd2);
    end
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, ".do_en"}, 32'(do_en), 32'd0);
    check({tag, ".do_last"}, 32'(do_last), 32'd0);
    check({tag, ".do_idx"}, 32'(do_idx), 32'd0);
    check({tag, ".do_re"}, do_re, 32'd0);
    check({tag, ".do_im"}, do_im, 32'd0);
  endtask

  initial begin
    bit found;

    reset_n = 1'b0;
    repeat (3) @(negedge clock);
    check_zero_outputs("reset");
    reset_n = 1'b1;
    idle(2);

    clear_q();
    send_frame(0, 0);
    idle(N + 10);
    check_frames("ramp", 1, 0, 1'b1);

    clear_q();
    send_frame(0, 0);
    send_frame(1000, 0);
    send_frame(2000, 0);
    idle(N + 10);
    check_frames("b2b", 3, 1000, 1'b0);

    clear_q();
    send_frame(0, 2);
    idle(N + 10);
    check_frames("gap", 1, 0, 1'b1);

    clear_q();
    for (int j = 0; j < 100; j++) begin
      @(negedge clock);
      di_en = 1'b1;
      di_re = 32'(5000 + j);
      di_im = 32'(-(5000 + j));
    end
    @(negedge clock);
    di_en = 1'b0;
    reset_n = 1'b0;
    #1;
    check_zero_outputs("rst_midframe");
    idle(2);
    reset_n = 1'b1;
    send_frame(0, 0);
    idle(N + 10);
    check_frames("after_partial", 1, 0, 1'b1);

    clear_q();
    send_frame(0, 0);
    found = 1'b0;
    for (int t = 0; t < 400 && !found; t++) begin
      @(negedge clock);
      di_en = 1'b0;
      if (do_en === 1'b1 && do_idx == 8'd50) found = 1'b1;
    end
    check("idx50.found", 32'(found), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("rst_readout.do_en", 32'(do_en), 32'd0);
    check("rst_readout.do_idx", 32'(do_idx), 32'd0);
    idle(3);
    check("rst_readout.held", 32'(do_en), 32'd0);
    reset_n = 1'b1;
    clear_q();
    idle(300);
    check("rst_readout.no_output", q_re.size(), 0);

    clear_q();
    send_frame(0, 0);
    idle(N + 10);
    check_frames("recover", 1, 0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
